// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU sequencing stage.
//   - Datapath widths for the accumulator and argument registers.
//   - Default step-counter width and watchdog limit.
//   - Sequencer state encoding.
package xc_malu_pkg;

    localparam int unsigned XC_MALU_ACC_W     = 64;
    localparam int unsigned XC_MALU_ARG_W     = 32;
    localparam int unsigned XC_MALU_CW        = 6;
    localparam int unsigned XC_MALU_MAX_COUNT = 40;

    typedef enum logic [1:0] {
        XC_MALU_IDLE = 2'd0,
        XC_MALU_RUN  = 2'd1,
        XC_MALU_DONE = 2'd2
    } xc_malu_state_t;

endpackage

// File: rtl/xc_malu_seq.sv
// Sequencer for the multi-cycle MALU step datapath.
// Latches operands on issue, holds the count/acc/arg_0 state that feeds the
// external combinational step function, loads back its next values each
// cycle and presents the final accumulator with a ready/ack handshake.
// Ports:
//   clock, reset       - clock and asynchronous active-high reset
//   flush              - abandon the current op (highest priority)
//   valid, ack         - issue held by execute until ready&&ack; result consumed
//   init_acc/arg_0     - operand seeds, sampled on accept
//   n_acc/n_arg_0      - next state from the step datapath
//   step_done          - step datapath reports its final step this cycle
//   count/acc/arg_0    - current state presented to the step datapath
//   busy, ready        - running / result available
//   result, err        - final accumulator and watchdog flag, zero unless ready
module xc_malu_seq
    import xc_malu_pkg::*;
#(
    parameter int unsigned CW        = XC_MALU_CW,
    parameter int unsigned MAX_COUNT = XC_MALU_MAX_COUNT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     valid,
    input  logic                     ack,
    input  logic [XC_MALU_ACC_W-1:0] init_acc,
    input  logic [XC_MALU_ARG_W-1:0] init_arg_0,
    input  logic [XC_MALU_ACC_W-1:0] n_acc,
    input  logic [XC_MALU_ARG_W-1:0] n_arg_0,
    input  logic                     step_done,
    output logic [CW-1:0]            count,
    output logic [XC_MALU_ACC_W-1:0] acc,
    output logic [XC_MALU_ARG_W-1:0] arg_0,
    output logic                     busy,
    output logic [XC_MALU_ACC_W-1:0] result,
    output logic                     ready,
    output logic                     err
);

    localparam logic [CW-1:0] MAX_COUNT_C = CW'(MAX_COUNT);

    xc_malu_state_t           state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [XC_MALU_ACC_W-1:0] acc_q, acc_d;
    logic [XC_MALU_ARG_W-1:0] arg_0_q, arg_0_d;
    logic                     err_q, err_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= XC_MALU_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            arg_0_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            arg_0_q <= arg_0_d;
            err_q   <= err_d;
        end
    end

    // Next state and register loads. Every return to IDLE clears the
    // registers so an abandoned op leaves nothing behind for the datapath.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        arg_0_d = arg_0_q;
        err_d   = err_q;
        case (state_q)
            XC_MALU_IDLE: begin
                if (valid && !flush) begin
                    state_d = XC_MALU_RUN;
                    acc_d   = init_acc;
                    arg_0_d = init_arg_0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            XC_MALU_RUN: begin
                if (flush || !valid) begin
                    state_d = XC_MALU_IDLE;
                    count_d = '0;
                    acc_d   = '0;
                    arg_0_d = '0;
                    err_d   = 1'b0;
                end else begin
                    arg_0_d = n_arg_0;
                    if (step_done) begin
                        state_d = XC_MALU_DONE;
                        acc_d   = n_acc;
                    end else if (count_q == MAX_COUNT_C) begin
                        // Watchdog: keep the accumulator as it stood at expiry.
                        state_d = XC_MALU_DONE;
                        err_d   = 1'b1;
                    end else begin
                        acc_d   = n_acc;
                        count_d = (count_q == '1) ? count_q : count_q + CW'(1);
                    end
                end
            end
            XC_MALU_DONE: begin
                if (flush || !valid || ack) begin
                    state_d = XC_MALU_IDLE;
                    count_d = '0;
                    acc_d   = '0;
                    arg_0_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = XC_MALU_IDLE;
                count_d = '0;
                acc_d   = '0;
                arg_0_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == XC_MALU_RUN);
        ready  = (state_q == XC_MALU_DONE);
        count  = count_q;
        acc    = acc_q;
        arg_0  = arg_0_q;
        result = ready ? acc_q : '0;
        err    = ready & err_q;
    end

endmodule

// File: tb/tb_xc_malu_seq.sv
module tb_xc_malu_seq;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        valid;
    logic        ack;
    logic [63:0] init_acc;
    logic [31:0] init_arg_0;
    logic [63:0] n_acc;
    logic [31:0] n_arg_0;
    logic        step_done;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] arg_0;
    logic        busy;
    logic [63:0] result;
    logic        ready;
    logic        err;

    // Step datapath model: acc += arg_0, arg_0 += arg_inc, final step at count == done_at.
    logic [31:0] arg_inc;
    logic [7:0]  done_at;

    assign n_acc     = acc + {32'b0, arg_0};
    assign n_arg_0   = arg_0 + arg_inc;
    assign step_done = busy && ({2'b00, count} == done_at);

    xc_malu_seq #(.CW(6), .MAX_COUNT(40)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .valid      (valid),
        .ack        (ack),
        .init_acc   (init_acc),
        .init_arg_0 (init_arg_0),
        .n_acc      (n_acc),
        .n_arg_0    (n_arg_0),
        .step_done  (step_done),
        .count      (count),
        .acc        (acc),
        .arg_0      (arg_0),
        .busy       (busy),
        .result     (result),
        .ready      (ready),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] init_acc;
        logic [31:0] init_arg;
        logic [31:0] inc;
        logic [7:0]  done_at;
        logic [63:0] exp_result;
        logic        exp_err;
        int unsigned exp_lat;   // edges from the accept edge until ready is seen
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic        err;
    } exp_t;

    vec_t vecs [7];
    exp_t sb_q [$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero_state(input string name);
        check({name, ".busy"},   {63'b0, busy},  64'd0);
        check({name, ".ready"},  {63'b0, ready}, 64'd0);
        check({name, ".acc"},    acc,            64'd0);
        check({name, ".arg_0"},  {32'b0, arg_0}, 64'd0);
        check({name, ".count"},  {58'b0, count}, 64'd0);
    endtask

    task automatic issue(input logic [63:0] ia, input logic [31:0] iarg,
                         input logic [31:0] inc, input logic [7:0] da);
        init_acc   = ia;
        init_arg_0 = iarg;
        arg_inc    = inc;
        done_at    = da;
        valid      = 1'b1;
    endtask

    task automatic compare_sb(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.sb: got completion expected none", name);
        end else begin
            e = sb_q.pop_front();
            check({name, ".result"}, result, e.result);
            check({name, ".err"}, {63'b0, err}, {63'b0, e.err});
        end
    endtask

    // Waits from the negedge before the accept edge; returns at the negedge where ready is seen.
    task automatic wait_ready(input string name, input int unsigned limit, output int unsigned lat,
                              output bit got);
        got = 0;
        lat = 0;
        @(posedge clock);
        for (int unsigned c = 0; c < limit && !got; c++) begin
            @(negedge clock);
            if (busy && ready) check({name, ".busy_ready_excl"}, 64'd1, 64'd0);
            if (ready) begin
                got = 1;
                lat = c;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: got no ready expected ready within %0d", name, limit);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int unsigned lat;
        bit got;
        string name;
        name = $sformatf("vec%0d", idx);
        @(negedge clock);
        issue(v.init_acc, v.init_arg, v.inc, v.done_at);
        sb_q.push_back('{v.exp_result, v.exp_err});
        wait_ready(name, 100, lat, got);
        if (got) begin
            check({name, ".latency"}, 64'(lat), 64'(v.exp_lat));
            compare_sb(name);
        end else begin
            void'(sb_q.pop_front());
        end
        ack   = 1'b1;
        valid = 1'b0;
        @(negedge clock);
        ack = 1'b0;
        check({name, ".idle_after_ack"}, {62'b0, busy, ready}, 64'd0);
    endtask

    initial begin
        int unsigned lat;
        bit got;
        bit seen;

        vecs[0] = '{64'h7, 32'd3, 32'd0, 8'd3, 64'h13, 1'b0, 4};
        vecs[1] = '{64'h100, 32'd2, 32'd1, 8'd0, 64'h102, 1'b0, 1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF0, 32'h10, 32'd0, 8'd1, 64'h10, 1'b0, 2};
        vecs[3] = '{64'h0, 32'd1, 32'd2, 8'd4, 64'h19, 1'b0, 5};
        vecs[4] = '{64'h1000, 32'd5, 32'd0, 8'hFF, 64'h10C8, 1'b1, 41};
        vecs[5] = '{64'h0, 32'd0, 32'd1, 8'hFF, 64'h30C, 1'b1, 41};
        vecs[6] = '{64'h0, 32'd1, 32'd0, 8'd40, 64'h29, 1'b0, 41};

        reset = 1'b1; flush = 1'b0; valid = 1'b0; ack = 1'b0;
        init_acc = '0; init_arg_0 = '0; arg_inc = '0; done_at = 8'hFF;
        #12;
        check_zero_state("reset");
        check("reset.result", result, 64'd0);
        check("reset.err", {63'b0, err}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // valid and flush together in IDLE: no accept.
        @(negedge clock);
        issue(64'hABCD, 32'd9, 32'd0, 8'd2);
        flush = 1'b1;
        @(negedge clock);
        check_zero_state("vflush_idle");
        valid = 1'b0;
        flush = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Flush in RUN at count 2.
        @(negedge clock);
        issue(64'h1, 32'd4, 32'd0, 8'd10);
        @(posedge clock);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (count == 6'd2) seen = 1;
        end
        check("flush.reach_count2", {63'b0, seen}, 64'd1);
        flush = 1'b1;
        valid = 1'b0;
        @(negedge clock);
        flush = 1'b0;
        check_zero_state("flush_run");
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (ready) seen = 1;
        end
        check("flush.no_ready", {63'b0, seen}, 64'd0);

        // DONE held without ack, then ack with valid high starts the next op.
        @(negedge clock);
        issue(64'h7, 32'd3, 32'd0, 8'd3);
        sb_q.push_back('{64'h13, 1'b0});
        wait_ready("hold", 20, lat, got);
        if (got) compare_sb("hold");
        else void'(sb_q.pop_front());
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("hold.stable%0d", c), {ready, result[62:0]}, {1'b1, 63'h13});
        end
        ack = 1'b1;
        issue(64'h50, 32'd3, 32'd0, 8'd0);
        sb_q.push_back('{64'h53, 1'b0});
        @(negedge clock);
        ack = 1'b0;
        check("rearm.idle", {62'b0, busy, ready}, 64'd0);
        @(negedge clock);
        check("rearm.run", {63'b0, busy}, 64'd1);
        check("rearm.acc", acc, 64'h50);
        @(negedge clock);
        check("rearm.ready", {63'b0, ready}, 64'd1);
        if (ready) compare_sb("rearm");
        ack = 1'b1;
        valid = 1'b0;
        @(negedge clock);
        ack = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (ready || busy) seen = 1;
        end
        check("rearm.no_dup", {63'b0, seen}, 64'd0);

        // valid dropped in DONE without ack returns to IDLE.
        @(negedge clock);
        issue(64'h20, 32'd1, 32'd0, 8'd1);
        wait_ready("vdrop", 20, lat, got);
        valid = 1'b0;
        @(negedge clock);
        check("vdrop.idle", {62'b0, busy, ready}, 64'd0);

        // Asynchronous reset between edges while running.
        @(negedge clock);
        issue(64'h99, 32'd7, 32'd0, 8'd30);
        @(posedge clock);
        for (int c = 0; c < 3; c++) @(negedge clock);
        check("areset.pre_busy", {63'b0, busy}, 64'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check_zero_state("areset");
        check("areset.result", result, 64'd0);
        @(negedge clock);
        valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("areset.idle", {62'b0, busy, ready}, 64'd0);

        check("sb.empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule
